// File: rtl/tank_game_sequencer.sv
// tank_game_sequencer
//   Runs once per frame. Each frame visits four slots in a fixed order: the
//   first player's tank, the first player's projectile, the other player's
//   tank, then the other player's projectile. The first player alternates
//   every frame. For each slot that has work, the sequencer drives a storage
//   access mode and a direction code for four cycles and pulses load_out in
//   the third of those cycles.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   tick                        one-cycle frame-start pulse
//   p1_move_valid/_dir/_fire    player 1 requests (dir: 00 up, 01 down, 10 left, 11 right)
//   p2_move_valid/_dir/_fire    player 2 requests
//   mode, data, load_out        registered storage access controls
//   busy                        high whenever the sequencer is not idle
//   frame_done                  one-cycle pulse at the end of a frame
//   overrun                     sticky; a tick arrived while busy
//   p1_proj_active/p2_...       projectile in flight, per player
module tank_game_sequencer #(
  parameter int         PROJ_RANGE = 15,
  parameter logic [3:0] IDLE_MODE  = 4'b1110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       p1_move_valid,
  input  logic [1:0] p1_move_dir,
  input  logic       p1_fire,
  input  logic       p2_move_valid,
  input  logic [1:0] p2_move_dir,
  input  logic       p2_fire,
  output logic [3:0] mode,
  output logic [7:0] data,
  output logic       load_out,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       p1_proj_active,
  output logic       p2_proj_active
);

  localparam logic [7:0] RANGE_U8 = 8'(PROJ_RANGE);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETUP, S_COMPUTE, S_LOAD, S_COMMIT, S_DONE
  } state_t;

  function automatic logic [7:0] dir_code(input logic [1:0] d);
    case (d)
      2'b00:   dir_code = 8'h00;
      2'b01:   dir_code = 8'h01;
      2'b10:   dir_code = 8'h03;
      default: dir_code = 8'h07;
    endcase
  endfunction

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic       first_reg, first_next;        // 0: P1 goes first this frame
  logic [1:0] slot_dir_reg, slot_dir_next;  // move dir captured for last_dir
  logic       slot_launch_reg, slot_launch_next;
  logic [3:0] mode_reg, mode_next;
  logic [7:0] data_reg, data_next;
  logic       load_reg, load_next;
  logic       done_reg, done_next;
  logic       busy_reg, busy_next;
  logic       overrun_reg, overrun_next;

  // Per-player request inputs and state, indexed 0 = P1, 1 = P2.
  logic [1:0]      move_valid_vec, fire_vec;
  logic [1:0][1:0] move_dir_vec;
  logic [1:0]      pending_move_vec, pending_fire_vec, proj_active_vec;
  logic [1:0][1:0] pending_dir_vec, last_dir_vec, proj_dir_vec;

  // Per-player control strobes from the sequencer.
  logic [1:0] launch, discard_fire, consume_move, consume_fire, step_proj;

  assign move_valid_vec = {p2_move_valid, p1_move_valid};
  assign fire_vec       = {p2_fire, p1_fire};
  assign move_dir_vec   = {p2_move_dir, p1_move_dir};

  // Slot decode: index bit 1 selects first/other player, bit 0 tank/proj.
  logic       cur_player, cur_proj, slot_needed;
  logic [3:0] slot_mode;
  logic [7:0] slot_code;

  always_comb begin
    cur_player  = idx_reg[1] ^ first_reg;
    cur_proj    = idx_reg[0];
    slot_mode   = {1'b0, cur_player, cur_proj, 1'b1};
    if (cur_proj) begin
      slot_needed = proj_active_vec[cur_player] | pending_fire_vec[cur_player];
      slot_code   = proj_active_vec[cur_player] ? dir_code(proj_dir_vec[cur_player])
                                                : dir_code(last_dir_vec[cur_player]);
    end else begin
      slot_needed = pending_move_vec[cur_player];
      slot_code   = dir_code(pending_dir_vec[cur_player]);
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    first_next       = first_reg;
    slot_dir_next    = slot_dir_reg;
    slot_launch_next = slot_launch_reg;
    launch           = '0;
    discard_fire     = '0;
    consume_move     = '0;
    consume_fire     = '0;
    step_proj        = '0;
    overrun_next     = overrun_reg | (tick && (state_reg != S_IDLE));

    case (state_reg)
      S_IDLE: begin
        if (tick) begin
          state_next = S_SELECT;
          idx_next   = 2'd0;
        end
      end
      S_SELECT: begin
        if (slot_needed) begin
          state_next       = S_SETUP;
          slot_dir_next    = pending_dir_vec[cur_player];
          slot_launch_next = cur_proj && !proj_active_vec[cur_player];
          if (cur_proj) begin
            if (proj_active_vec[cur_player])
              discard_fire[cur_player] = pending_fire_vec[cur_player];
            else
              launch[cur_player] = 1'b1;
          end
        end else if (idx_reg == 2'd3) begin
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + 2'd1;
        end
      end
      S_SETUP:   state_next = S_COMPUTE;
      S_COMPUTE: state_next = S_LOAD;
      S_LOAD:    state_next = S_COMMIT;
      S_COMMIT: begin
        if (cur_proj) begin
          step_proj[cur_player] = 1'b1;
          // Only a launching slot consumes the fire request; a fire seen
          // while in flight was already discarded at selection time.
          consume_fire[cur_player] = slot_launch_reg;
        end else begin
          consume_move[cur_player] = 1'b1;
        end
        if (idx_reg == 2'd3) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SELECT;
          idx_next   = idx_reg + 2'd1;
        end
      end
      S_DONE: begin
        first_next = ~first_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are computed from the next state and registered, so they
    // line up with the state they describe and never see inputs directly.
    mode_next = IDLE_MODE;
    data_next = 8'h00;
    if (state_reg == S_SELECT && state_next == S_SETUP) begin
      mode_next = slot_mode;
      data_next = slot_code;
    end else if (state_next == S_SETUP || state_next == S_COMPUTE ||
                 state_next == S_LOAD  || state_next == S_COMMIT) begin
      mode_next = mode_reg;
      data_next = data_reg;
    end
    load_next = (state_next == S_LOAD);
    done_next = (state_next == S_DONE);
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      idx_reg         <= 2'd0;
      first_reg       <= 1'b0;
      slot_dir_reg    <= 2'b00;
      slot_launch_reg <= 1'b0;
      mode_reg        <= IDLE_MODE;
      data_reg        <= 8'h00;
      load_reg        <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      first_reg       <= first_next;
      slot_dir_reg    <= slot_dir_next;
      slot_launch_reg <= slot_launch_next;
      mode_reg        <= mode_next;
      data_reg        <= data_next;
      load_reg        <= load_next;
      done_reg        <= done_next;
      busy_reg        <= busy_next;
      overrun_reg     <= overrun_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic       pending_move_reg, pending_fire_reg, proj_active_reg;
      logic [1:0] pending_dir_reg, last_dir_reg, proj_dir_reg;
      logic [7:0] step_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          pending_move_reg <= 1'b0;
          pending_fire_reg <= 1'b0;
          proj_active_reg  <= 1'b0;
          pending_dir_reg  <= 2'b00;
          last_dir_reg     <= (gi == 0) ? 2'b01 : 2'b00;
          proj_dir_reg     <= 2'b00;
          step_reg         <= 8'd0;
        end else begin
          // New requests take precedence over a same-cycle clear.
          if (move_valid_vec[gi]) begin
            pending_move_reg <= 1'b1;
            pending_dir_reg  <= move_dir_vec[gi];
          end else if (consume_move[gi]) begin
            pending_move_reg <= 1'b0;
          end
          if (consume_move[gi])
            last_dir_reg <= slot_dir_reg;

          if (fire_vec[gi])
            pending_fire_reg <= 1'b1;
          else if (consume_fire[gi] || discard_fire[gi])
            pending_fire_reg <= 1'b0;

          if (launch[gi]) begin
            proj_active_reg <= 1'b1;
            proj_dir_reg    <= last_dir_reg;
            step_reg        <= 8'd0;
          end else if (step_proj[gi]) begin
            step_reg <= step_reg + 8'd1;
            if (step_reg + 8'd1 == RANGE_U8)
              proj_active_reg <= 1'b0;
          end
        end
      end

      assign pending_move_vec[gi] = pending_move_reg;
      assign pending_fire_vec[gi] = pending_fire_reg;
      assign proj_active_vec[gi]  = proj_active_reg;
      assign pending_dir_vec[gi]  = pending_dir_reg;
      assign last_dir_vec[gi]     = last_dir_reg;
      assign proj_dir_vec[gi]     = proj_dir_reg;
    end
  endgenerate

  assign mode           = mode_reg;
  assign data           = data_reg;
  assign load_out       = load_reg;
  assign busy           = busy_reg;
  assign frame_done     = done_reg;
  assign overrun        = overrun_reg;
  assign p1_proj_active = proj_active_vec[0];
  assign p2_proj_active = proj_active_vec[1];

endmodule
